// File: rtl/tto_mon_pkg.sv
// Shared constants, state encodings and the nibble-to-ASCII helper for the
// TinyTapeout output UART monitor.
package tto_mon_pkg;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam int         FIFO_DEPTH = 4;
    localparam int         PTR_W      = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {
        FRM_IDLE,
        FRM_SEND
    } frame_state_e;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_START,
        SER_DATA,
        SER_STOP
    } ser_state_e;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART serializer, LSB first. A new byte is taken when idle or in the
// final stop-bit cycle (done), so back-to-back bytes have no gap.
module uart_tx_byte
    import tto_mon_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       done,
    output logic       tx
);
    localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    ser_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             bit_end;
    logic             take;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        done    = 1'b0;
        ready   = (state_q == SER_IDLE);
        bit_end = (cnt_q == CNT_LAST);

        // The counter reloads every bit, so bit boundaries never drift.
        if (state_q != SER_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            SER_IDLE: ;
            SER_START: begin
                if (bit_end) state_d = SER_DATA;
            end
            SER_DATA: begin
                if (bit_end) begin
                    shreg_d = {1'b0, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = SER_STOP;
                end
            end
            SER_STOP: begin
                if (bit_end) begin
                    done    = 1'b1;
                    state_d = SER_IDLE;
                end
            end
            default: state_d = SER_IDLE;
        endcase

        take = valid && (ready || done);
        if (take) begin
            state_d = SER_START;
            shreg_d = data;
            bit_d   = '0;
            cnt_d   = '0;
        end

        unique case (state_q)
            SER_START: tx_d = 1'b0;
            SER_DATA:  tx_d = shreg_q[0];
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: state is updated with <= so every flop samples its pre-edge inputs.
        if (rst) begin
            state_q <= SER_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

    assign tx = tx_q;

endmodule

// File: rtl/tto_out_uart_monitor.sv
// Samples the TinyTapeout DUT output bus on each divided-clock rising edge and
// reports every changed value over the UART as two hex digits plus CR LF.
module tto_out_uart_monitor
    import tto_mon_pkg::*;
#(
    parameter int CLK_HZ       = 12000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       dut_clk,
    input  logic [7:0] dut_out,
    output logic       tx,
    output logic       busy,
    output logic       overflow,
    output logic [7:0] drop_count
);
    localparam int IDX_W = PTR_W - 1;

    logic             dut_clk_q, dut_clk_d;
    logic             first_pending_q, first_pending_d;
    logic [7:0]       last_q, last_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_count_q, drop_count_d;
    frame_state_e     fstate_q, fstate_d;
    logic [7:0]       frame_q, frame_d;
    logic [1:0]       char_idx_q, char_idx_d;

    logic       fifo_empty, fifo_full;
    logic       sample, want, push;
    logic       ser_valid, ser_ready, ser_done;
    logic [7:0] ser_data;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                        (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

    // Edge detect, change filter and FIFO write side.
    always_comb begin
        dut_clk_d       = dut_clk;
        first_pending_d = first_pending_q;
        last_d          = last_q;
        wr_ptr_d        = wr_ptr_q;
        mem_d           = mem_q;
        overflow_d      = overflow_q;
        drop_count_d    = drop_count_q;

        sample = dut_clk && !dut_clk_q;
        want   = sample && (first_pending_q || (dut_out != last_q));
        // Full is taken from the registered pointers, so a same-cycle pop cannot rescue a push.
        push   = want && !fifo_full;

        if (push) begin
            mem_d[wr_ptr_q[IDX_W-1:0]] = dut_out;
            wr_ptr_d                   = wr_ptr_q + 1'b1;
            last_d                     = dut_out;
            first_pending_d            = 1'b0;
        end else if (want) begin
            overflow_d = 1'b1;
            if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
        end
    end

    // Frame FSM. It advances on each accepted character, so the next character is
    // already waiting when the serializer finishes and frames run back to back.
    always_comb begin
        fstate_d   = fstate_q;
        frame_d    = frame_q;
        char_idx_d = char_idx_q;
        rd_ptr_d   = rd_ptr_q;
        ser_valid  = 1'b0;

        unique case (char_idx_q)
            2'd0:    ser_data = hex_ascii(frame_q[7:4]);
            2'd1:    ser_data = hex_ascii(frame_q[3:0]);
            2'd2:    ser_data = ASCII_CR;
            default: ser_data = ASCII_LF;
        endcase

        unique case (fstate_q)
            FRM_IDLE: begin
                if (!fifo_empty) begin
                    frame_d    = mem_q[rd_ptr_q[IDX_W-1:0]];
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    char_idx_d = '0;
                    fstate_d   = FRM_SEND;
                end
            end
            FRM_SEND: begin
                ser_valid = 1'b1;
                if (ser_ready || ser_done) begin
                    if (char_idx_q == 2'd3) fstate_d = FRM_IDLE;
                    else                    char_idx_d = char_idx_q + 2'd1;
                end
            end
            default: fstate_d = FRM_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        dut_clk_q <= dut_clk_d;
        if (rst) begin
            first_pending_q <= 1'b1;
            last_q          <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            overflow_q      <= 1'b0;
            drop_count_q    <= '0;
            fstate_q        <= FRM_IDLE;
            frame_q         <= '0;
            char_idx_q      <= '0;
        end else begin
            first_pending_q <= first_pending_d;
            last_q          <= last_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            overflow_q      <= overflow_d;
            drop_count_q    <= drop_count_d;
            fstate_q        <= fstate_d;
            frame_q         <= frame_d;
            char_idx_q      <= char_idx_d;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .CLK  (CLK),
        .rst  (rst),
        .valid(ser_valid),
        .data (ser_data),
        .ready(ser_ready),
        .done (ser_done),
        .tx   (tx)
    );

    assign busy       = !fifo_empty || (fstate_q == FRM_SEND) || !ser_ready;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_tto_out_uart_monitor.sv
// Randomised and directed bench for tto_out_uart_monitor: a UART receiver decodes
// tx and checks each byte against a queue filled by a sample-level reference model.
`timescale 1ns/1ps
module tb_tto_out_uart_monitor;
    import tto_mon_pkg::*;

    localparam int CPB = 104;

    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic       dut_clk = 1'b0;
    logic [7:0] dut_out = 8'h00;
    logic       tx, busy, overflow;
    logic [7:0] drop_count;

    tto_out_uart_monitor #(
        .CLK_HZ(12000000),
        .BAUD  (115200)
    ) dut (
        .CLK       (CLK),
        .rst       (rst),
        .dut_clk   (dut_clk),
        .dut_out   (dut_out),
        .tx        (tx),
        .busy      (busy),
        .overflow  (overflow),
        .drop_count(drop_count)
    );

    always #5 CLK = ~CLK;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    int         epoch = 0;

    // Reference model state: what the monitor has queued, last reported value, drops.
    bit         m_first;
    logic [7:0] m_last;
    int         m_drops;
    bit         m_ovf;
    int         m_slots;
    string      hexs = "0123456789ABCDEF";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_first = 1'b1;
        m_last  = 8'h00;
        m_drops = 0;
        m_ovf   = 1'b0;
        m_slots = 0;
    endtask

    // From an idle monitor, one sample is taken straight into the framer and
    // FIFO_DEPTH more fit in the FIFO before anything is dropped.
    task automatic start_burst();
        m_slots = FIFO_DEPTH + 1;
    endtask

    task automatic model_sample(input logic [7:0] v);
        if (m_first || v != m_last) begin
            if (m_slots > 0) begin
                m_slots--;
                m_first = 1'b0;
                m_last  = v;
                exp_q.push_back(8'(hexs[int'(v[7:4])]));
                exp_q.push_back(8'(hexs[int'(v[3:0])]));
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
            end else begin
                m_ovf = 1'b1;
                if (m_drops < 255) m_drops++;
            end
        end
    endtask

    task automatic pulse_sample(input logic [7:0] v);
        @(negedge CLK);
        dut_out = v;
        dut_clk = 1'b1;
        model_sample(v);
        @(negedge CLK);
        dut_clk = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        @(negedge CLK);
        while (busy !== 1'b0 && k < budget) begin
            @(negedge CLK);
            k++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic wait_tx_low(input int budget);
        int k = 0;
        @(negedge CLK);
        while (tx !== 1'b0 && k < budget) begin
            @(negedge CLK);
            k++;
        end
        check("tx_start_seen", 32'(tx), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        rst = 1'b1;
        epoch++;
        exp_q.delete();
        model_reset();
        @(posedge CLK);
        #1;
        check("rst_tx_high", 32'(tx), 32'd1);
        check("rst_busy_low", 32'(busy), 32'd0);
        @(negedge CLK);
        rst = 1'b0;
    endtask

    task automatic measure_run(input logic level, output int len);
        len = 0;
        do begin
            @(posedge CLK);
            #1;
            len++;
        end while (tx === level && len < 5000);
    endtask

    // UART receiver: samples at bit centres and compares against the scoreboard.
    initial begin : rx_mon
        logic [7:0] b;
        logic       stopb;
        int         ep;
        forever begin
            @(negedge CLK);
            if (tx === 1'b0) begin
                ep = epoch;
                repeat (CPB / 2) @(negedge CLK);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge CLK);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge CLK);
                stopb = tx;
                if (ep == epoch) begin
                    check("rx_stop_bit", 32'(stopb), 32'd1);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL rx_unexpected_byte: got 0x%02h, wanted no byte", b);
                    end else begin
                        check("rx_byte", 32'(b), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        repeat (99000) @(posedge CLK);
        $display("FAIL watchdog: got no finish within 99000 cycles, wanted completion");
        $fatal(1, "bench timed out");
    end

    initial begin : stim
        int lat;
        int run;
        int nb;
        logic [7:0] v;

        model_reset();
        repeat (3) @(negedge CLK);
        do_reset();
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_drop_count", 32'(drop_count), 32'd0);

        // A5 from idle: latency and bit widths of the first character 'A' (0x41).
        start_burst();
        @(negedge CLK);
        dut_out = 8'hA5;
        dut_clk = 1'b1;
        model_sample(8'hA5);
        @(posedge CLK);
        @(negedge CLK);
        dut_clk = 1'b0;
        lat = 0;
        do begin
            @(posedge CLK);
            #1;
            lat++;
        end while (tx !== 1'b0 && lat < 20);
        check("first_start_latency", 32'(lat), 32'd3);
        measure_run(1'b0, run);
        check("start_bit_width", 32'(run), 32'(CPB));
        measure_run(1'b1, run);
        check("a_bit0_width", 32'(run), 32'(CPB));
        measure_run(1'b0, run);
        check("a_bits1to5_width", 32'(run), 32'(5 * CPB));
        wait_idle(6000, "idle_after_a5");

        // Repeated values collapse to one frame each.
        start_burst();
        pulse_sample(8'h3C);
        pulse_sample(8'h3C);
        pulse_sample(8'h3C);
        pulse_sample(8'h07);
        wait_idle(12000, "idle_after_3c_07");
        repeat (4) @(negedge CLK);
        check("sb_drained_repeat", 32'(exp_q.size()), 32'd0);

        // Six fast distinct samples: one in flight, four queued, one dropped.
        start_burst();
        pulse_sample(8'h11);
        pulse_sample(8'h22);
        pulse_sample(8'h33);
        pulse_sample(8'h44);
        pulse_sample(8'h55);
        pulse_sample(8'h66);
        @(negedge CLK);
        check("burst_overflow", 32'(overflow), 32'(m_ovf));
        check("burst_drop_count", 32'(drop_count), 32'(m_drops));
        wait_idle(25000, "idle_after_burst");
        repeat (4) @(negedge CLK);
        check("sb_drained_burst", 32'(exp_q.size()), 32'd0);

        // Heavy backpressure: drop counter saturates, overflow is sticky until reset.
        start_burst();
        for (int i = 0; i < 305; i++) begin
            pulse_sample(8'((i * 53 + 7) & 255));
        end
        @(negedge CLK);
        check("sat_drop_count", 32'(drop_count), 32'(m_drops));
        check("sat_overflow", 32'(overflow), 32'(m_ovf));
        repeat (500) @(negedge CLK);
        check("sat_overflow_sticky", 32'(overflow), 32'(m_ovf));
        do_reset();
        check("post_rst_overflow", 32'(overflow), 32'd0);
        check("post_rst_drop_count", 32'(drop_count), 32'd0);
        repeat (1200) @(negedge CLK);

        // First sample after reset equal to last_q's reset value is still reported.
        start_burst();
        pulse_sample(8'h00);
        wait_idle(6000, "idle_after_00");
        repeat (4) @(negedge CLK);
        check("sb_drained_00", 32'(exp_q.size()), 32'd0);

        // Reset during char1 data bits, then resend the same value.
        start_burst();
        pulse_sample(8'h5A);
        wait_tx_low(20);
        repeat (14 * CPB) @(negedge CLK);
        do_reset();
        repeat (1200) @(negedge CLK);
        start_burst();
        pulse_sample(8'h5A);
        wait_idle(6000, "idle_after_5a_resend");
        repeat (4) @(negedge CLK);
        check("sb_drained_5a", 32'(exp_q.size()), 32'd0);

        // Random short bursts drawn from a small alphabet to exercise the filter.
        for (int b = 0; b < 3; b++) begin
            start_burst();
            nb = int'($urandom_range(1, 2));
            for (int j = 0; j < nb; j++) begin
                v = 8'($urandom_range(0, 2)) * 8'h55;
                if ($urandom_range(0, 3) == 0) v = 8'($urandom);
                pulse_sample(v);
                repeat ($urandom_range(0, 3)) @(negedge CLK);
            end
            wait_idle(12000, "idle_after_random");
        end
        repeat (4) @(negedge CLK);
        check("sb_drained_random", 32'(exp_q.size()), 32'd0);
        check("final_drop_count", 32'(drop_count), 32'(m_drops));
        check("final_overflow", 32'(overflow), 32'(m_ovf));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
